// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER RV32I MCU: fetch, execute, writeback and
// interrupt entry, with stalls on the data-memory handshake.
module otter_cu_fsm #(
    parameter int unsigned IMM_SEL_W = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [6:0]           CU_opcode,
    input  logic [2:0]           CU_func3,
    input  logic                 CU_intr,
    input  logic                 CU_mie,
    input  logic                 CU_dmem_ready,
    output logic                 CU_rst,
    output logic                 CU_pc_write,
    output logic                 CU_reg_write,
    output logic                 CU_mem_rden1,
    output logic                 CU_mem_rden2,
    output logic                 CU_mem_we2,
    output logic                 CU_csr_we,
    output logic                 CU_int_taken,
    output logic [IMM_SEL_W-1:0] CU_imm_sel,
    output logic [2:0]           CU_state
);

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StWb    = 3'd3,
        StIntr  = 3'd4
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [IMM_SEL_W-1:0] ImmI = IMM_SEL_W'(0);
    localparam logic [IMM_SEL_W-1:0] ImmS = IMM_SEL_W'(1);
    localparam logic [IMM_SEL_W-1:0] ImmB = IMM_SEL_W'(2);
    localparam logic [IMM_SEL_W-1:0] ImmU = IMM_SEL_W'(3);
    localparam logic [IMM_SEL_W-1:0] ImmJ = IMM_SEL_W'(4);

    state_e r_state;
    state_e w_state_next;
    state_e w_exit_state;
    logic   r_intr_pending;
    logic   w_is_load;
    logic   w_store_stall;

    assign w_is_load     = (CU_opcode == OpLoad);
    assign w_store_stall = (CU_opcode == OpStore) && !CU_dmem_ready;
    // Interrupts are only taken at an instruction boundary.
    assign w_exit_state  = r_intr_pending ? StIntr : StFetch;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state        <= StInit;
            r_intr_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Leaving INTR clears the request even if a new one arrives on the same edge.
            if (r_state == StIntr) begin
                r_intr_pending <= 1'b0;
            end else if (CU_intr && CU_mie) begin
                r_intr_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = StInit;
        case (r_state)
            StInit:  w_state_next = StFetch;
            StFetch: w_state_next = StExec;
            StExec: begin
                if (w_is_load) begin
                    w_state_next = StWb;
                end else if (w_store_stall) begin
                    w_state_next = StExec;
                end else begin
                    w_state_next = w_exit_state;
                end
            end
            StWb:    w_state_next = CU_dmem_ready ? w_exit_state : StWb;
            StIntr:  w_state_next = StFetch;
            default: w_state_next = StInit;
        endcase
    end

    always_comb begin
        CU_rst       = 1'b0;
        CU_pc_write  = 1'b0;
        CU_reg_write = 1'b0;
        CU_mem_rden1 = 1'b0;
        CU_mem_rden2 = 1'b0;
        CU_mem_we2   = 1'b0;
        CU_csr_we    = 1'b0;
        CU_int_taken = 1'b0;
        CU_imm_sel   = ImmI;
        case (r_state)
            StInit:  CU_rst = 1'b1;
            StFetch: CU_mem_rden1 = 1'b1;
            StExec: begin
                case (CU_opcode)
                    OpLoad: CU_mem_rden2 = 1'b1;
                    OpStore: begin
                        CU_mem_we2  = 1'b1;
                        CU_imm_sel  = ImmS;
                        CU_pc_write = CU_dmem_ready;
                    end
                    OpOp, OpImm, OpJalr: begin
                        CU_reg_write = 1'b1;
                        CU_pc_write  = 1'b1;
                    end
                    OpLui, OpAuipc: begin
                        CU_reg_write = 1'b1;
                        CU_pc_write  = 1'b1;
                        CU_imm_sel   = ImmU;
                    end
                    OpJal: begin
                        CU_reg_write = 1'b1;
                        CU_pc_write  = 1'b1;
                        CU_imm_sel   = ImmJ;
                    end
                    OpBranch: begin
                        CU_pc_write = 1'b1;
                        CU_imm_sel  = ImmB;
                    end
                    OpSystem: begin
                        CU_pc_write = 1'b1;
                        if (CU_func3 == 3'b001) begin
                            CU_csr_we    = 1'b1;
                            CU_reg_write = 1'b1;
                        end
                    end
                    // Illegal opcodes retire as a NOP.
                    default: CU_pc_write = 1'b1;
                endcase
            end
            StWb: begin
                CU_reg_write = CU_dmem_ready;
                CU_pc_write  = CU_dmem_ready;
            end
            StIntr: begin
                CU_int_taken = 1'b1;
                CU_pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign CU_state = r_state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: directed walk through the main instruction classes,
// interrupt entry and reset, then randomized traffic against a reference model.
module tb_otter_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [6:0] CU_opcode;
    logic [2:0] CU_func3;
    logic       CU_intr;
    logic       CU_mie;
    logic       CU_dmem_ready;
    logic       CU_rst;
    logic       CU_pc_write;
    logic       CU_reg_write;
    logic       CU_mem_rden1;
    logic       CU_mem_rden2;
    logic       CU_mem_we2;
    logic       CU_csr_we;
    logic       CU_int_taken;
    logic [2:0] CU_imm_sel;
    logic [2:0] CU_state;

    int errors = 0;
    int checks = 0;

    // Reference model: state as plain integer, pending as a bit.
    int m_state;
    bit m_pend;

    typedef struct packed {
        logic       rst;
        logic       pcw;
        logic       rw;
        logic       rd1;
        logic       rd2;
        logic       we2;
        logic       csr;
        logic       intk;
        logic [2:0] imm;
    } exp_t;

    always #5 CLK = ~CLK;

    otter_cu_fsm #(.IMM_SEL_W(3)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CU_opcode    (CU_opcode),
        .CU_func3     (CU_func3),
        .CU_intr      (CU_intr),
        .CU_mie       (CU_mie),
        .CU_dmem_ready(CU_dmem_ready),
        .CU_rst       (CU_rst),
        .CU_pc_write  (CU_pc_write),
        .CU_reg_write (CU_reg_write),
        .CU_mem_rden1 (CU_mem_rden1),
        .CU_mem_rden2 (CU_mem_rden2),
        .CU_mem_we2   (CU_mem_we2),
        .CU_csr_we    (CU_csr_we),
        .CU_int_taken (CU_int_taken),
        .CU_imm_sel   (CU_imm_sel),
        .CU_state     (CU_state)
    );

    // Expected outputs in a state, straight from the instruction-class table.
    function automatic exp_t model_out(input int st, input logic [6:0] op,
                                       input logic [2:0] f3, input logic dr);
        exp_t e;
        e = '0;
        if (st == 0) e.rst = 1'b1;
        else if (st == 1) e.rd1 = 1'b1;
        else if (st == 2) begin
            if (op == 7'b0000011) e.rd2 = 1'b1;
            else if (op == 7'b0100011) begin
                e.we2 = 1'b1; e.imm = 3'd1; e.pcw = dr;
            end else if (op == 7'b1100011) begin
                e.pcw = 1'b1; e.imm = 3'd2;
            end else if (op == 7'b1101111) begin
                e.pcw = 1'b1; e.rw = 1'b1; e.imm = 3'd4;
            end else if (op == 7'b0110111 || op == 7'b0010111) begin
                e.pcw = 1'b1; e.rw = 1'b1; e.imm = 3'd3;
            end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100111) begin
                e.pcw = 1'b1; e.rw = 1'b1;
            end else if (op == 7'b1110011) begin
                e.pcw = 1'b1;
                if (f3 == 3'b001) begin e.csr = 1'b1; e.rw = 1'b1; end
            end else e.pcw = 1'b1;
        end else if (st == 3) begin
            e.pcw = dr; e.rw = dr;
        end else if (st == 4) begin
            e.intk = 1'b1; e.pcw = 1'b1;
        end
        return e;
    endfunction

    function automatic int model_next(input int st, input bit pend,
                                      input logic [6:0] op, input logic dr);
        int boundary;
        boundary = pend ? 4 : 1;
        case (st)
            0: return 1;
            1: return 2;
            2: begin
                if (op == 7'b0000011) return 3;
                if (op == 7'b0100011 && !dr) return 2;
                return boundary;
            end
            3: return dr ? boundary : 3;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, clock, advance model.
    task automatic cyc(input string tag, input logic rn, input logic [6:0] op,
                       input logic [2:0] f, input logic it, input logic m, input logic dr);
        exp_t e;
        int   nxt;
        #1;
        RST_N = rn; CU_opcode = op; CU_func3 = f; CU_intr = it; CU_mie = m;
        CU_dmem_ready = dr;
        #1;
        e = model_out(m_state, op, f, dr);
        chk({tag, ":state"},  {5'b0, CU_state},     8'(m_state));
        chk({tag, ":rst"},    {7'b0, CU_rst},       {7'b0, e.rst});
        chk({tag, ":pcw"},    {7'b0, CU_pc_write},  {7'b0, e.pcw});
        chk({tag, ":regw"},   {7'b0, CU_reg_write}, {7'b0, e.rw});
        chk({tag, ":rden1"},  {7'b0, CU_mem_rden1}, {7'b0, e.rd1});
        chk({tag, ":rden2"},  {7'b0, CU_mem_rden2}, {7'b0, e.rd2});
        chk({tag, ":we2"},    {7'b0, CU_mem_we2},   {7'b0, e.we2});
        chk({tag, ":csrwe"},  {7'b0, CU_csr_we},    {7'b0, e.csr});
        chk({tag, ":intk"},   {7'b0, CU_int_taken}, {7'b0, e.intk});
        chk({tag, ":immsel"}, {5'b0, CU_imm_sel},   {5'b0, e.imm});
        @(posedge CLK);
        if (!rn) begin
            m_state = 0;
            m_pend  = 1'b0;
        end else begin
            nxt     = model_next(m_state, m_pend, op, dr);
            m_pend  = (m_state == 4) ? 1'b0 : (m_pend | (it & m));
            m_state = nxt;
        end
    endtask

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;

    logic [6:0] ops [11];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100011, 7'b1110011, 7'b0000000};
        RST_N = 1'b0; CU_opcode = '0; CU_func3 = '0; CU_intr = 1'b0; CU_mie = 1'b0;
        CU_dmem_ready = 1'b1;
        // First reset edge establishes a known state for the model.
        @(posedge CLK);
        m_state = 0;
        m_pend  = 1'b0;
        cyc("rst1", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("rst2", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);

        // ADDI: 0,1,2,1
        cyc("addi_init",  1'b1, ADDI, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("addi_fetch", 1'b1, ADDI, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("addi_exec",  1'b1, ADDI, 3'd0, 1'b0, 1'b0, 1'b1);

        // LW with two not-ready WB cycles
        cyc("lw_fetch", 1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b1);
        cyc("lw_exec",  1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("lw_wb0",   1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("lw_wb1",   1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("lw_wb2",   1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b1);

        // SW stalled one cycle
        cyc("sw_fetch", 1'b1, SW, 3'd2, 1'b0, 1'b0, 1'b1);
        cyc("sw_exec0", 1'b1, SW, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("sw_exec1", 1'b1, SW, 3'd2, 1'b0, 1'b0, 1'b1);

        // BEQ, JAL, LUI immediate formats
        cyc("beq_fetch", 1'b1, BEQ, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("beq_exec",  1'b1, BEQ, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("jal_fetch", 1'b1, JAL, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("jal_exec",  1'b1, JAL, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("lui_fetch", 1'b1, LUI, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("lui_exec",  1'b1, LUI, 3'd0, 1'b0, 1'b0, 1'b1);

        // Interrupt pulse in FETCH with mie=1, then ADD -> INTR -> FETCH
        cyc("irq_fetch", 1'b1, ADD, 3'd0, 1'b1, 1'b1, 1'b1);
        cyc("irq_exec",  1'b1, ADD, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("irq_intr",  1'b1, ADD, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("irq_clr_f", 1'b1, ADD, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("irq_clr_e", 1'b1, ADD, 3'd0, 1'b0, 1'b1, 1'b1);
        // Same pulse with mie=0: no interrupt
        cyc("nomie_f",   1'b1, ADD, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc("nomie_e",   1'b1, ADD, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("nomie_f2",  1'b1, ADD, 3'd0, 1'b0, 1'b0, 1'b1);

        // Reset during a stalled WB aborts the load
        cyc("rwb_exec",  1'b1, LW, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("rwb_wb",    1'b0, LW, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("rwb_init",  1'b1, LW, 3'd0, 1'b0, 1'b0, 1'b0);

        // Illegal opcode behaves as NOP
        cyc("ill_fetch", 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("ill_exec",  1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("ill_after", 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [6:0] op;
            logic       rn;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
            rn = ($urandom_range(0, 49) != 0);
            cyc("rand", rn, op, 3'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
